// File: rtl/reg_write_arbiter.sv
// Round-robin write controller: shares one register-bank write path among
// NUM_REQ requesters, issuing a one-cycle set strobe, write data and ack.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for any request; grants the round-robin winner
// ST_WRITE | one-cycle write: ack/set/err/busy valid, pointer advances
module reg_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic [NUM_REQ-1:0]             req_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  data_in,
    output logic [NUM_REQ-1:0]             ack_out,
    output logic [NUM_REGS-1:0]            set_out,
    output logic [DATA_WIDTH-1:0]          wdata_out,
    output logic                           err_out,
    output logic                           busy_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       win_idx_q;
    logic [PTR_W-1:0]       ptr_next;
    logic [PTR_W:0]         cand;
    logic                   pick_valid;
    logic [PTR_W-1:0]       pick_idx;
    logic [ADDR_WIDTH-1:0]  pick_addr;
    logic [DATA_WIDTH-1:0]  pick_data;
    logic                   pick_in_range;

    // Scan requesters from rr_ptr upward (wrapping) and take the first active one
    always_comb begin
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!pick_valid && req_in[cand[PTR_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Select the winner's address and data slices
    always_comb begin
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_addr = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Extra MSB lets NUM_REGS == 2^ADDR_WIDTH compare without overflow
    assign pick_in_range = ({1'b0, pick_addr} < (ADDR_WIDTH+1)'(NUM_REGS));

    assign ptr_next = (win_idx_q == PTR_W'(NUM_REQ-1)) ? '0 : win_idx_q + 1'b1;

    // Arbitration FSM with registered strobes; wdata holds until the next grant
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            win_idx_q <= '0;
            ack_out   <= '0;
            set_out   <= '0;
            err_out   <= 1'b0;
            busy_out  <= 1'b0;
            wdata_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_WRITE;
                        win_idx_q <= pick_idx;
                        ack_out   <= NUM_REQ'(1) << pick_idx;
                        set_out   <= pick_in_range ? (NUM_REGS'(1) << pick_addr) : '0;
                        err_out   <= !pick_in_range;
                        wdata_out <= pick_data;
                        busy_out  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state    <= ST_IDLE;
                    rr_ptr   <= ptr_next;
                    ack_out  <= '0;
                    set_out  <= '0;
                    err_out  <= 1'b0;
                    busy_out <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: two arbiters (4-register and 3-register banks) share
// the same stimulus and are compared against a behavioural model each cycle.
module tb_reg_write_arbiter;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic [3:0]  req_in;
    logic [7:0]  addr_in;
    logic [15:0] data_in;

    logic [3:0]  ack_a, set_a, wdata_a;
    logic        err_a, busy_a;
    logic [3:0]  ack_b, wdata_b;
    logic [2:0]  set_b;
    logic        err_b, busy_b;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock_in = ~clock_in;

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(4), .ADDR_WIDTH(2), .DATA_WIDTH(4)) dut_a (
        .clock_in(clock_in), .reset_in(reset_in), .req_in(req_in), .addr_in(addr_in),
        .data_in(data_in), .ack_out(ack_a), .set_out(set_a), .wdata_out(wdata_a),
        .err_out(err_a), .busy_out(busy_a)
    );

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(3), .ADDR_WIDTH(2), .DATA_WIDTH(4)) dut_b (
        .clock_in(clock_in), .reset_in(reset_in), .req_in(req_in), .addr_in(addr_in),
        .data_in(data_in), .ack_out(ack_b), .set_out(set_b), .wdata_out(wdata_b),
        .err_out(err_b), .busy_out(busy_b)
    );

    // Register banks fed by the arbiters; writes are dropped while in reset
    logic [3:0] bank_a [4];
    logic [3:0] bank_b [3];
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            for (int i = 0; i < 4; i++) bank_a[i] <= '0;
            for (int i = 0; i < 3; i++) bank_b[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) if (set_a[i]) bank_a[i] <= wdata_a;
            for (int i = 0; i < 3; i++) if (set_b[i]) bank_b[i] <= wdata_b;
        end
    end

    // Behavioural model state
    logic       m_busy  = 1'b0;
    int         m_ptr   = 0;
    int         m_win   = 0;
    logic [3:0] m_ack   = '0;
    logic [3:0] m_set_a = '0;
    logic [2:0] m_set_b = '0;
    logic       m_err_a = 1'b0;
    logic       m_err_b = 1'b0;
    logic [3:0] m_wdata = '0;
    logic [3:0] mbank_a [4];
    logic [3:0] mbank_b [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance model and DUTs by one clock edge, then compare everything
    task automatic cycle();
        int  a;
        bit  found;
        if (reset_in) begin
            for (int i = 0; i < 4; i++) if (m_set_a[i]) mbank_a[i] = m_wdata;
            for (int i = 0; i < 3; i++) if (m_set_b[i]) mbank_b[i] = m_wdata;
        end else begin
            for (int i = 0; i < 4; i++) mbank_a[i] = '0;
            for (int i = 0; i < 3; i++) mbank_b[i] = '0;
        end
        m_ack = '0; m_set_a = '0; m_set_b = '0; m_err_a = 1'b0; m_err_b = 1'b0;
        if (!reset_in) begin
            m_busy = 1'b0; m_ptr = 0; m_wdata = '0;
        end else if (m_busy) begin
            m_busy = 1'b0;
            m_ptr  = (m_win + 1) % 4;
        end else if (req_in != 4'b0000) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req_in[(m_ptr + k) % 4]) begin
                    found = 1'b1;
                    m_win = (m_ptr + k) % 4;
                end
            end
            a       = int'(addr_in[m_win*2 +: 2]);
            m_wdata = data_in[m_win*4 +: 4];
            m_ack   = 4'(1 << m_win);
            m_set_a = 4'(1 << a);
            if (a < 3) m_set_b = 3'(1 << a);
            else       m_err_b = 1'b1;
            m_busy  = 1'b1;
        end
        @(posedge clock_in);
        #1;
        chk("ack_a", ack_a, m_ack);
        chk("set_a", set_a, m_set_a);
        chk("err_a", err_a, m_err_a);
        chk("wdata_a", wdata_a, m_wdata);
        chk("busy_a", busy_a, m_busy);
        chk("ack_b", ack_b, m_ack);
        chk("set_b", set_b, m_set_b);
        chk("err_b", err_b, m_err_b);
        chk("wdata_b", wdata_b, m_wdata);
        chk("busy_b", busy_b, m_busy);
        for (int i = 0; i < 4; i++) chk($sformatf("bank_a[%0d]", i), bank_a[i], mbank_a[i]);
        for (int i = 0; i < 3; i++) chk($sformatf("bank_b[%0d]", i), bank_b[i], mbank_b[i]);
    endtask

    initial begin
        logic [3:0] d;
        int         grants;

        // Reset held with all requests active: nothing granted
        reset_in = 1'b0;
        req_in   = 4'b1111;
        addr_in  = {2'd3, 2'd2, 2'd1, 2'd0};
        data_in  = 16'h4321;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("reset_ack", ack_a, 32'h0);
            chk("reset_busy", busy_a, 32'h0);
        end

        // Round-robin with all requesters held: 0,1,2,3,0 on odd cycles
        reset_in = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cycle();
            if (c % 2 == 1) chk("rr_order", ack_a, 32'(1 << (((c - 1) / 2) % 4)));
            else            chk("rr_gap", ack_a, 32'h0);
        end
        chk("rr_bank3", bank_a[3], 32'h4);

        // Idle gap
        req_in = 4'b0000;
        cycle();
        cycle();

        // Single write: requester 2, addr 3, data A (out of range on 3-register bank)
        req_in  = 4'b0100;
        addr_in = {2'd0, 2'd3, 2'd0, 2'd0};
        data_in = 16'h0A00;
        cycle();
        chk("single_set", set_a, 32'h8);
        chk("single_wdata", wdata_a, 32'hA);
        chk("single_ack", ack_a, 32'h4);
        req_in = 4'b0000;
        cycle();
        chk("single_ack_drop", ack_a, 32'h0);
        cycle();
        chk("single_bank3", bank_a[3], 32'hA);

        // Out-of-range on the 3-register bank: requester 1, addr 3
        req_in  = 4'b0010;
        addr_in = {2'd0, 2'd0, 2'd3, 2'd0};
        data_in = 16'h0050;
        cycle();
        chk("oor_ack", ack_b, 32'h2);
        chk("oor_err", err_b, 32'h1);
        chk("oor_set", set_b, 32'h0);
        req_in = 4'b0000;
        cycle();
        cycle();

        // Reset during WRITE: grant 2, then reset; next grant goes to requester 1
        req_in  = 4'b0100;
        addr_in = {2'd2, 2'd1, 2'd1, 2'd0};
        data_in = 16'h7654;
        cycle();
        chk("mid_ack2", ack_a, 32'h4);
        reset_in = 1'b0;
        req_in   = 4'b1010;
        cycle();
        chk("mid_reset_set", set_a, 32'h0);
        chk("mid_reset_ack", ack_a, 32'h0);
        reset_in = 1'b1;
        cycle();
        chk("mid_first_grant", ack_a, 32'h2);
        req_in = 4'b0000;
        cycle();
        cycle();

        // Back-to-back from requester 3, new data after every ack
        d       = 4'h1;
        grants  = 0;
        req_in  = 4'b1000;
        addr_in = {2'd1, 2'd0, 2'd0, 2'd0};
        data_in = {d, 12'h000};
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (m_ack[3]) begin
                grants++;
                chk("b2b_wdata", wdata_a, 32'(d));
                d       = d + 4'h3;
                data_in = {d, 12'h000};
            end
        end
        chk("b2b_grants", 32'(grants), 32'd4);
        req_in = 4'b0000;
        cycle();
        cycle();

        // Randomised traffic following the requester protocol, occasional resets
        for (int c = 0; c < 600; c++) begin
            cycle();
            reset_in = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < 4; i++) begin
                if (m_ack[i]) begin
                    req_in[i] = $urandom_range(0, 1) == 1;
                    addr_in[i*2 +: 2] = 2'($urandom_range(0, 3));
                    data_in[i*4 +: 4] = 4'($urandom_range(0, 15));
                end else if (!req_in[i] && $urandom_range(0, 3) == 0) begin
                    req_in[i] = 1'b1;
                    addr_in[i*2 +: 2] = 2'($urandom_range(0, 3));
                    data_in[i*4 +: 4] = 4'($urandom_range(0, 15));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write controller that shares the single write path of a bank of general-purpose registers among several requesters. Each requester presents an address and data word. The block grants one requester at a time and drives a one-cycle set pulse to the addressed register together with the write data. It also returns a one-cycle acknowledge to the winner. It sits between requesting units and a bank of `NUM_REGS` register instances, whose set inputs are driven from `set_out` and whose data inputs are all driven from `wdata_out`.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `NUM_REGS`, 4, number of registers in the bank (1..2^`ADDR_WIDTH`)
- `ADDR_WIDTH`, 2, register address width
- `DATA_WIDTH`, 4, register data width
- `clock_in`  in  1  single clock, all logic on rising edge
- `reset_in`  in  1  synchronous, active-low reset (0 = reset)
- `req_in`  in  `NUM_REQ`  per-requester write request, level
- `addr_in`  in  `NUM_REQ*ADDR_WIDTH`  requester i address in slice [i*`ADDR_WIDTH` +: `ADDR_WIDTH`]
- `data_in`  in  `NUM_REQ*DATA_WIDTH`  requester i data in slice [i*`DATA_WIDTH` +: `DATA_WIDTH`]
- `ack_out`  out  `NUM_REQ`  one-hot, one-cycle write acknowledge
- `set_out`  out  `NUM_REGS`  one-hot, one-cycle register set strobe
- `wdata_out`  out  `DATA_WIDTH`  write data to all registers
- `err_out`  out  1  one-cycle pulse: granted address ≥ `NUM_REGS`
- `busy_out`  out  1  high while in WRITE

## Operation
- Two-state FSM: IDLE, WRITE. All outputs are registered.
- **IDLE:**
  - If no bit of `req_in` is set: stay in IDLE.
  - Otherwise pick the winner: scan from `rr_ptr` upward, modulo `NUM_REQ`, and take the first requester with its request set.
  - Latch the winner index, its address slice and its data slice, then go to WRITE.
- **WRITE (exactly one cycle):**
  - Set `ack_out[winner]` to 1.
  - If the latched address is below `NUM_REGS`: set `set_out[addr]` to 1. Otherwise `set_out` stays all-zero and `err_out` is 1.
  - `wdata_out` holds the latched data and is held until the next grant.
  - `busy_out` is 1.
  - Next state is IDLE. `rr_ptr` becomes (winner+1) mod `NUM_REQ`.
- **Requester protocol:**
  - Hold `req_in`, address and data stable from assertion until `ack_out` is sampled high.
  - Drop `req_in` on the edge where `ack_out` is sampled. Data sampled after the grant edge is ignored.
  - Keeping `req_in` high after the ack means a new, independent request.
- **Fairness:** a requester that keeps its request asserted is granted within `NUM_REQ` grants.
- **Reset** (`reset_in`=0 at a rising edge):
  - State goes to IDLE and `rr_ptr` to 0.
  - `ack_out`, `set_out`, `err_out` and `busy_out` go to 0.
  - `wdata_out` goes to 0.
- **Reset during WRITE:** outputs are forced to 0 at that edge. The interrupted write is not retried and no ack is given for it.
- **Simultaneous requests:** only one grant per arbitration, chosen in round-robin order. Losers keep waiting with no penalty.

## Timing
- Request sampled at edge k (IDLE) → `set_out`, `ack_out`, `wdata_out` and `busy_out` are valid during cycle k..k+1.
- The register captures the data at edge k+1. Its output is updated after edge k+1.
- The FSM returns to IDLE at edge k+1. The next grant edge is k+2 at the earliest.
- Peak throughput is one write per 2 cycles.
- `ack_out`, `set_out` and `err_out` are never high for two consecutive cycles.
- `wdata_out` changes only on grant edges or on reset.

## Test plan
- **Reset:** hold `reset_in`=0 for 3 cycles with `req_in`=4'b1111. All outputs are 0 and no ack is given. Release reset: the first grant goes to requester 0.
- **Single write:** requester 2 requests with addr=3, data=4'hA. After 1 cycle, `set_out`=4'b1000, `wdata_out`=4'hA and `ack_out`=4'b0100, all for one cycle. Register 3 reads 4'hA afterwards.
- **Round-robin:** all four requesters held high. Acks appear in order 0,1,2,3,0 on cycles 1,3,5,7,9 after reset release.
- **Out-of-range address:** `NUM_REGS`=3, requester 1 writes addr=3. `ack_out`=4'b0010 and `err_out`=1, with `set_out`=0. No register changes.
- **Reset mid-write:** pull `reset_in` low on the WRITE cycle. `set_out` and `ack_out` return to 0, the write is dropped and `rr_ptr` is 0. The first grant after release goes to the lowest active requester.
- **Back-to-back from one requester:** requester 3 keeps `req_in` high and changes data each ack. It is granted every 2 cycles, and each `wdata_out` matches the data presented at that grant.
